// File: rtl/step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// step_ctrl_pkg
//   Shared definitions for the single-step controller: the externally visible
//   mode encodings, the FSM state type built on them, the default step counter
//   width, and a helper that sizes the debounce counter.
// -----------------------------------------------------------------------------
package step_ctrl_pkg;

  // Encodings presented on the mode output (and shown on the board).
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_HALTED = 2'b10;

  // Default width of the step counter driving the HEX displays.
  localparam int DEFAULT_COUNT_W = 16;

  // The state encoding is the mode encoding, so mode is a plain copy of state.
  typedef enum logic [1:0] {
    ST_MANUAL = MODE_MANUAL,
    ST_RUN    = MODE_RUN,
    ST_HALTED = MODE_HALTED
  } state_t;

  // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Synchronises an asynchronous active-low pushbutton, filters contact bounce
//   and reports each accepted press as a single-cycle pulse.
//
//   A change on the synchronised key is accepted only after it has differed
//   from the debounced level for DEBOUNCE_CYCLES consecutive samples. Any
//   sample that agrees with the debounced level restarts the count.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   key_n  in   raw pushbutton, asynchronous, 0 = pressed
//   press  out  one-cycle pulse when the debounced key goes pressed
// -----------------------------------------------------------------------------
module key_debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_s;
  logic [CNT_W-1:0]       cnt;
  logic                   key_db;
  logic                   key_db_d;

  // Synchroniser resets to the released level so reset never looks like a press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end
  end

  assign key_s = sync_q[SYNC_STAGES-1];

  // Counter measures how long key_s has disagreed with key_db; the last count
  // slot is where the new level is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
    end else begin
      key_db_d <= key_db;
      if (key_s == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_db <= key_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level only; releases produce nothing.
  assign press = key_db_d & ~key_db;

endmodule

// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//   Converts auto-run ticks (rising edges of clk_1Hz) or debounced KEY presses
//   into single-cycle cpu_en pulses that advance the processor one instruction,
//   and counts the pulses issued.
//
//   Modes: MANUAL (key steps), RUN (clk_1Hz steps), HALTED (processor asked to
//   stop; left only once halt is low and the run switch is off).
//   An event is qualified by the state in the cycle it is detected; events in a
//   non-qualifying state are dropped, never queued.
//
// Ports
//   clk_50MHz   in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   clk_1Hz     in   slow square wave, already synchronous to clk_50MHz
//   run_sw      in   slide switch, asynchronous, 1 = auto-run
//   step_key_n  in   pushbutton, asynchronous, 0 = pressed
//   halt        in   synchronous stop request from the processor
//   cpu_en      out  one-cycle processor clock enable
//   step_count  out  cpu_en pulses since reset, wraps silently
//   mode        out  00 MANUAL, 01 RUN, 10 HALTED
// -----------------------------------------------------------------------------
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int COUNT_W         = DEFAULT_COUNT_W
) (
  input  logic               clk_50MHz,
  input  logic               reset_n,
  input  logic               clk_1Hz,
  input  logic               run_sw,
  input  logic               step_key_n,
  input  logic               halt,
  output logic               cpu_en,
  output logic [COUNT_W-1:0] step_count,
  output logic [1:0]         mode
);

  logic [SYNC_STAGES-1:0] run_sync_q;
  logic                   run_s;
  logic                   clk_1hz_d;
  logic                   tick;
  logic                   press;
  logic                   pulse;
  state_t                 state;
  state_t                 state_next;

  // ---------------------------------------------------------------------------
  // Key path: synchroniser, debounce and press detection.
  // ---------------------------------------------------------------------------
  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_key_debouncer (
    .clk   (clk_50MHz),
    .rst_n (reset_n),
    .key_n (step_key_n),
    .press (press)
  );

  // ---------------------------------------------------------------------------
  // Run switch synchroniser (resets to "not running").
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      run_sync_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[SYNC_STAGES-2:0], run_sw};
    end
  end

  assign run_s = run_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Auto-run tick. clk_1Hz is already in this domain, so one register suffices.
  // The delayed copy resets high so a clk_1Hz that is high when reset releases
  // is not mistaken for a fresh rising edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      clk_1hz_d <= 1'b1;
    end else begin
      clk_1hz_d <= clk_1Hz;
    end
  end

  assign tick = clk_1Hz & ~clk_1hz_d;

  // ---------------------------------------------------------------------------
  // Mode FSM: next state and pulse qualification. halt overrides everything,
  // including an event detected in the same cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pulse      = 1'b0;
    if (halt) begin
      state_next = ST_HALTED;
    end else begin
      case (state)
        ST_MANUAL: begin
          pulse = press;
          if (run_s) state_next = ST_RUN;
        end
        ST_RUN: begin
          pulse = tick;
          if (!run_s) state_next = ST_MANUAL;
        end
        ST_HALTED: begin
          if (!run_s) state_next = ST_MANUAL;
        end
        default: begin
          state_next = ST_MANUAL;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State, pulse and counter registers. cpu_en and the counter update on the
  // same edge, so the count already includes the pulse being shown.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_MANUAL;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= state_next;
      cpu_en <= pulse;
      if (pulse) step_count <= step_count + 1'b1;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_step_controller.sv
// -----------------------------------------------------------------------------
// tb_step_controller
//   Self-checking bench for step_controller with a short debounce window and a
//   400 ns clk_1Hz. A behavioural model predicts cpu_en, step_count and mode
//   every cycle; directed scenarios add hand-computed expectations, followed by
//   a randomized phase.
// -----------------------------------------------------------------------------
module tb_step_controller;
  import step_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int CW   = 16;

  logic          clk_50MHz  = 1'b0;
  logic          reset_n    = 1'b0;
  logic          clk_1Hz    = 1'b1;
  logic          run_sw     = 1'b0;
  logic          step_key_n = 1'b1;
  logic          halt       = 1'b0;
  logic          cpu_en;
  logic [CW-1:0] step_count;
  logic [1:0]    mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  bit chk_en = 1'b1;
  bit preload = 1'b0;

  step_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SYNC),
    .COUNT_W         (CW)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .clk_1Hz    (clk_1Hz),
    .run_sw     (run_sw),
    .step_key_n (step_key_n),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .step_count (step_count),
    .mode       (mode)
  );

  // 50 MHz clock; clk_1Hz toggles every 200 ns, always on a falling clk edge.
  always #10 clk_50MHz = ~clk_50MHz;
  initial forever #200 clk_1Hz = ~clk_1Hz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  always @(negedge clk_50MHz) begin
    if (cpu_en === 1'b1) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  //   run_s / key_s : the input as sampled SYNC edges earlier
  //   debounce      : accept a new key level once it has disagreed with the
  //                   accepted level for DEB consecutive samples
  //   press         : accepted level went 1 -> 0 on the previous edge
  //   tick          : clk_1Hz sampled high now and low at the previous edge
  // ---------------------------------------------------------------------------
  bit          run_q[$];
  bit          key_q[$];
  int          m_diff;
  bit          m_db, m_fell, m_clk1_prev, m_cpu_en;
  logic [1:0]  m_mode;
  logic [CW-1:0] m_count;

  task automatic model_reset();
    run_q.delete();
    key_q.delete();
    for (int i = 0; i < SYNC; i++) begin
      run_q.push_back(1'b0);
      key_q.push_back(1'b1);
    end
    m_diff      = 0;
    m_db        = 1'b1;
    m_fell      = 1'b0;
    m_clk1_prev = 1'b1;
    m_mode      = MODE_MANUAL;
    m_cpu_en    = 1'b0;
    m_count     = '0;
  endtask

  task automatic model_step();
    bit run_s, key_s, tick, press, pulse;
    run_s = run_q.pop_front();
    run_q.push_back(run_sw);
    key_s = key_q.pop_front();
    key_q.push_back(step_key_n);

    tick        = clk_1Hz && !m_clk1_prev;
    m_clk1_prev = clk_1Hz;

    press  = m_fell;
    m_fell = 1'b0;
    if (key_s != m_db) begin
      m_diff++;
      if (m_diff == DEB) begin
        m_db   = key_s;
        m_diff = 0;
        m_fell = !key_s;
      end
    end else begin
      m_diff = 0;
    end

    pulse = 1'b0;
    if (halt) begin
      m_mode = MODE_HALTED;
    end else if (m_mode == MODE_MANUAL) begin
      pulse = press;
      if (run_s) m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN) begin
      pulse = tick;
      if (!run_s) m_mode = MODE_MANUAL;
    end else if (!run_s) begin
      m_mode = MODE_MANUAL;
    end

    m_cpu_en = pulse;
    if (preload) m_count = 16'hFFFF;
    else         m_count = m_count + CW'(pulse);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50MHz or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_50MHz) begin
    if (chk_en) begin
      check("cpu_en", 32'(cpu_en), 32'(m_cpu_en));
      check("step_count", 32'(step_count), 32'(m_count));
      check("mode", 32'(mode), 32'(m_mode));
    end
  end

  // Stimulus is applied 1 ns after a falling edge, well away from rising edges.
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50MHz);
    #1;
  endtask

  task automatic wait_mode(input logic [1:0] exp, input string name);
    int i;
    i = 0;
    while (mode !== exp && i < 20) begin
      wait_cycles(1);
      i++;
    end
    check(name, 32'(mode), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p0, c0, key_left;
    bit found;

    // Reset release while clk_1Hz is high: no tick, reset values held.
    wait_cycles(3);
    reset_n = 1'b1;
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_count", 32'(step_count), 32'd0);
    check("reset_mode", 32'(mode), 32'(MODE_MANUAL));
    wait_cycles(2);
    check("no_tick_after_reset", 32'(cpu_en), 32'd0);

    // Auto-run for five clk_1Hz periods.
    run_sw = 1'b1;
    wait_mode(MODE_RUN, "enter_run");
    p0 = pulse_cnt;
    repeat (5) @(posedge clk_1Hz);
    wait_cycles(3);
    check("run_pulses", 32'(pulse_cnt - p0), 32'd5);
    check("run_count", 32'(step_count), 32'd5);

    // Manual press held 10 cycles: one pulse, seven edges after the fall.
    run_sw = 1'b0;
    wait_mode(MODE_MANUAL, "leave_run");
    p0 = pulse_cnt;
    c0 = cyc;
    step_key_n = 1'b0;
    wait_cycles(10);
    check("press_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("press_latency", 32'(last_pulse_cyc - c0), 32'd7);
    step_key_n = 1'b1;
    wait_cycles(12);
    check("release_no_pulse", 32'(pulse_cnt - p0), 32'd1);
    check("press_count", 32'(step_count), 32'd6);

    // Two-cycle glitch is filtered.
    p0 = pulse_cnt;
    step_key_n = 1'b0;
    wait_cycles(2);
    step_key_n = 1'b1;
    wait_cycles(12);
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("glitch_count", 32'(step_count), 32'd6);

    // halt on the same cycle as a tick in RUN.
    run_sw = 1'b1;
    wait_mode(MODE_RUN, "reenter_run");
    @(posedge clk_1Hz);
    #1;
    halt = 1'b1;
    p0 = pulse_cnt;
    wait_cycles(2);
    check("halt_tick_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("halt_mode", 32'(mode), 32'(MODE_HALTED));
    halt = 1'b0;
    wait_cycles(5);
    check("halted_with_run_on", 32'(mode), 32'(MODE_HALTED));
    run_sw = 1'b0;
    wait_cycles(4);
    check("halted_exit", 32'(mode), 32'(MODE_MANUAL));

    // Preload the counter to all ones, then one press wraps it.
    chk_en  = 1'b0;
    force dut.step_count = 16'hFFFF;
    preload = 1'b1;
    wait_cycles(1);
    release dut.step_count;
    preload = 1'b0;
    chk_en  = 1'b1;
    check("preload_count", 32'(step_count), 32'h0000_FFFF);
    step_key_n = 1'b0;
    wait_cycles(10);
    step_key_n = 1'b1;
    wait_cycles(10);
    check("wrap_count", 32'(step_count), 32'd0);

    // Asynchronous reset in the middle of a pulse.
    step_key_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk_50MHz);
      #2;
      if (cpu_en === 1'b1) found = 1'b1;
    end
    check("pulse_before_reset", 32'(found), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midpulse_cpu_en", 32'(cpu_en), 32'd0);
    check("midpulse_count", 32'(step_count), 32'd0);
    check("midpulse_mode", 32'(mode), 32'(MODE_MANUAL));
    wait_cycles(3);
    reset_n = 1'b1;
    // Key still held: the restarted debouncer accepts it again.
    p0 = pulse_cnt;
    wait_cycles(10);
    check("press_after_reset", 32'(pulse_cnt - p0), 32'd1);
    step_key_n = 1'b1;
    wait_cycles(10);

    // Randomized phase, checked by the model.
    key_left = 0;
    for (int i = 0; i < 1500; i++) begin
      if (key_left == 0) begin
        step_key_n = ~step_key_n;
        key_left   = $urandom_range(1, 10);
      end else begin
        key_left--;
      end
      if ($urandom_range(0, 59) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 49) == 0) halt = ~halt;
      wait_cycles(1);
    end
    halt = 1'b0;
    wait_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Sits directly downstream of clock_divider and consumes its clk_1Hz output.
- Turns that slow square wave, or a debounced KEY press, into single-cycle cpu_en pulses. These pulses advance the DE1 processor one instruction at a time in the 50 MHz domain.
- Provides auto-run, manual-step and halted modes, plus a step counter for the HEX displays.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples needed to accept a key change (20 ms at 50 MHz). Minimum 2.
- SYNC_STAGES, 2: flip-flop depth of the synchronisers on run_sw and step_key_n. Minimum 2.
- COUNT_W, 16: width of step_count.

Ports:
- clk_50MHz  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  from clock_divider; already synchronous to clk_50MHz; a rising edge is an auto-run tick.
- run_sw  in  1  slide switch, asynchronous; 1 = auto-run.
- step_key_n  in  1  pushbutton, asynchronous, active-low (0 = pressed).
- halt  in  1  from processor, synchronous; 1 = stop issuing pulses.
- cpu_en  out  1  one-cycle-wide processor clock-enable pulse.
- step_count  out  COUNT_W  number of cpu_en pulses issued since reset.
- mode  out  2  current state: 00 MANUAL, 01 RUN, 10 HALTED.

Behaviour:
- Reset values: cpu_en=0, step_count=0, mode=MANUAL. Key synchroniser and debounced key = 1 (released). Switch synchroniser = 0. Debounce counter = 0. clk_1Hz_d = 1, so a clk_1Hz already high at reset release gives no tick.
- Tick detection: tick = clk_1Hz & ~clk_1Hz_d, where clk_1Hz_d is clk_1Hz registered once. clk_1Hz gets no synchroniser.
- Synchronisers: run_sw and step_key_n each pass through SYNC_STAGES flip-flops, giving run_s and key_s.
- Debounce:
  - The counter increments while key_s != key_db and clears to 0 whenever key_s == key_db.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, key_db takes key_s and the counter clears.
  - press = key_db falling from 1 to 0, one cycle wide. Release generates nothing.
- FSM (registered; halt has highest priority):
  - Any state, halt=1: go to HALTED. No pulse that cycle.
  - MANUAL: run_s=1 goes to RUN. press issues a pulse.
  - RUN: run_s=0 goes to MANUAL. tick issues a pulse. press is ignored.
  - HALTED: leave to MANUAL only when halt=0 and run_s=0. tick and press are ignored there.
- A pulse is qualified by the state in the cycle the tick or press is detected, before that cycle's transition.
- Latency: the edge that detects tick or press is edge k. cpu_en is high from edge k+1 to edge k+2, exactly one cycle.
- step_count increments on the same edge cpu_en goes high. It wraps from all-ones to 0 with no flag.
- Dropped events: events that occur in a non-qualifying state are dropped, not queued. A run_s change and a tick in the same cycle resolve by the current state.
- Asynchronous reset mid-pulse clears cpu_en immediately and restarts the debouncer.

Decomposition:
- Shared package step_ctrl_pkg: localparams MODE_MANUAL=2'b00, MODE_RUN=2'b01, MODE_HALTED=2'b10, and the default COUNT_W.
- One sub-module key_debouncer containing the synchroniser, counter and press output, parameterised by DEBOUNCE_CYCLES and SYNC_STAGES.
- The clk_1Hz edge detect and the FSM stay in step_controller.

Test Plan:
- Bench settings for all scenarios: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, and clk_1Hz driven as a 400 ns-period square wave so the simulation stays short.
- Reset release with clk_1Hz=1: expect no cpu_en, step_count=0, mode=00.
- run_sw=1 for 5 clk_1Hz periods: expect mode=01 after sync, exactly 5 one-cycle cpu_en pulses each 1 cycle after tick detection, step_count=5.
- run_sw=0, step_key_n held low 10 cycles: expect a single pulse at cycle 2+4+1 after the fall, and no pulse on release.
- step_key_n glitching low for only 2 cycles: expect no pulse and no step_count change.
- In RUN, halt=1 on the same cycle as a tick: expect no pulse and mode=10. Then halt=0 with run_sw still 1: expect mode stays 10. Then run_sw=0: expect mode=00.
- Preload step_count via 65535 manual presses, or force to 16'hFFFF, then one press: expect step_count=0.
- Assert reset_n during a cpu_en pulse: expect cpu_en=0 immediately and all reset values restored.
